bytestuffer_stream: RTL and testbench

- Parametrised successor to the JPEG byte stuffer: an elastic FIFO sitting between the entropy coder/bit packer and the output byte sink (UART/SPI/USB bridge).
- Inserts STUFF_BYTE after every ESCAPE_BYTE in entropy-coded data.
- Adds a per-byte raw flag so markers (e.g. FF D9 EOI) pass unstuffed.
- Adds input ready, output valid/ready backpressure, a fill-level output and sticky overflow on dropped writes.

---
 rtl/bytestuffer_stream.sv | 171 +++++++++++++++++
 tb/tb_bytestuffer_stream.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bytestuffer_stream.sv
// Elastic byte FIFO with escape stuffing on the read side: a non-raw ESCAPE_BYTE
// is followed on the output by STUFF_BYTE; raw-flagged bytes pass verbatim.
module bytestuffer_stream #(
    parameter int unsigned ADDR_WIDTH  = 9,
    parameter logic [7:0]  ESCAPE_BYTE = 8'hff,
    parameter logic [7:0]  STUFF_BYTE  = 8'h00
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  data_in_valid,
    input  logic [7:0]            data_in,
    input  logic                  data_in_raw,
    output logic                  data_in_ready,
    output logic                  data_out_valid,
    output logic [7:0]            data_out,
    input  logic                  data_out_ready,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  overflow
);

    localparam int unsigned AW    = ADDR_WIDTH;
    localparam int unsigned LW    = ADDR_WIDTH + 1;
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned EW    = 9;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_EMIT  = 2'd1,
        S_STUFF = 2'd2
    } state_e;

    logic [EW-1:0] mem_q [DEPTH];
    logic [EW-1:0] rd_data_q;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q,  level_d;
    logic          rd_stale_q, rd_stale_d;
    logic          overflow_q, overflow_d;

    state_e        state_q, state_d;
    logic [7:0]    dout_q,  dout_d;
    logic          raw_q,   raw_d;
    logic          valid_q, valid_d;

    logic          wr_en;
    logic          pop;
    logic          load;
    logic          xfer;
    logic          can_load;

    assign data_in_ready  = (level_q != LW'(DEPTH));
    assign data_out_valid = valid_q;
    assign data_out       = dout_q;
    assign level          = level_q;
    assign overflow       = overflow_q;

    assign wr_en    = data_in_valid && data_in_ready;
    assign xfer     = valid_q && data_out_ready;
    // The read register lags a write into an empty FIFO by one edge; wait for it.
    assign can_load = (level_q != '0) && !rd_stale_q;
    assign pop      = load;

    // Storage and registered read, prefetching the entry at the next read pointer
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= {data_in_raw, data_in};
        end
        rd_data_q <= mem_q[rd_ptr_d];
    end

    // Pointer, level, overflow and read-staleness bookkeeping
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        rd_stale_d = 1'b0;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        case ({wr_en, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        if (data_in_valid && !data_in_ready) begin
            overflow_d = 1'b1;
        end

        // New entry lands on the address being prefetched this same edge
        rd_stale_d = wr_en && (level_q == LW'(pop));
    end

    // Output state machine: next state and output register contents
    always_comb begin
        state_d = state_q;
        dout_d  = dout_q;
        raw_d   = raw_q;
        load    = 1'b0;

        case (state_q)
            S_EMPTY: begin
                load = can_load;
            end
            S_EMIT: begin
                if (xfer) begin
                    if ((dout_q == ESCAPE_BYTE) && !raw_q) begin
                        state_d = S_STUFF;
                        dout_d  = STUFF_BYTE;
                    end else if (can_load) begin
                        load = 1'b1;
                    end else begin
                        state_d = S_EMPTY;
                    end
                end
            end
            S_STUFF: begin
                if (xfer) begin
                    if (can_load) begin
                        load = 1'b1;
                    end else begin
                        state_d = S_EMPTY;
                    end
                end
            end
            default: begin
                state_d = S_EMPTY;
            end
        endcase

        if (load) begin
            state_d = S_EMIT;
            dout_d  = rd_data_q[7:0];
            raw_d   = rd_data_q[8];
        end

        valid_d = (state_d != S_EMPTY);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            rd_stale_q <= 1'b0;
            overflow_q <= 1'b0;
            state_q    <= S_EMPTY;
            dout_q     <= 8'h00;
            raw_q      <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            rd_stale_q <= rd_stale_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            dout_q     <= dout_d;
            raw_q      <= raw_d;
            valid_q    <= valid_d;
        end
    end

endmodule

// File: tb/tb_bytestuffer_stream.sv
// Scoreboard bench for bytestuffer_stream: a default-depth instance and a
// four-entry instance, each checked against a stuffing reference model.
module tb_bytestuffer_stream;

    localparam int unsigned DEPTH_A = 512;
    localparam int unsigned DEPTH_B = 4;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset;

    logic       a_in_valid, a_in_raw, a_in_ready, a_out_valid, a_out_ready, a_ovf;
    logic [7:0] a_in, a_out;
    logic [9:0] a_level;

    logic       b_in_valid, b_in_raw, b_in_ready, b_out_valid, b_out_ready, b_ovf;
    logic [7:0] b_in, b_out;
    logic [2:0] b_level;

    int tests_run = 0;
    int fails     = 0;

    logic [7:0] qa[$];
    logic [7:0] qb[$];
    logic       a_hold, b_hold;
    logic [7:0] a_hold_data, b_hold_data;
    logic       chk_b_level;

    bytestuffer_stream u_dut_a (
        .clock          (clock),
        .reset          (reset),
        .data_in_valid  (a_in_valid),
        .data_in        (a_in),
        .data_in_raw    (a_in_raw),
        .data_in_ready  (a_in_ready),
        .data_out_valid (a_out_valid),
        .data_out       (a_out),
        .data_out_ready (a_out_ready),
        .level          (a_level),
        .overflow       (a_ovf)
    );

    bytestuffer_stream #(.ADDR_WIDTH(2)) u_dut_b (
        .clock          (clock),
        .reset          (reset),
        .data_in_valid  (b_in_valid),
        .data_in        (b_in),
        .data_in_raw    (b_in_raw),
        .data_in_ready  (b_in_ready),
        .data_out_valid (b_out_valid),
        .data_out       (b_out),
        .data_out_ready (b_out_ready),
        .level          (b_level),
        .overflow       (b_ovf)
    );

    // Reference model: expected output bytes for one accepted input byte
    task automatic push_exp_a(input logic [7:0] d, input logic r);
        qa.push_back(d);
        if (d == 8'hff && !r) qa.push_back(8'h00);
    endtask

    task automatic push_exp_b(input logic [7:0] d, input logic r);
        qb.push_back(d);
        if (d == 8'hff && !r) qb.push_back(8'h00);
    endtask

    // One clock: scoreboard and hold checks mid-cycle, then return just after the edge
    task automatic tick();
        logic [7:0] exp;
        @(negedge clock);
        if (reset) begin
            a_hold = 1'b0;
            b_hold = 1'b0;
        end else begin
            if (a_hold) begin
                tests_run++;
                if (a_out_valid !== 1'b1 || a_out !== a_hold_data) begin
                    fails++;
                    $display("FAIL a_stall_hold: valid=%b data=%h, required valid=1 data=%h",
                             a_out_valid, a_out, a_hold_data);
                end
            end
            if (a_out_valid && a_out_ready) begin
                tests_run++;
                if (qa.size() == 0) begin
                    fails++;
                    $display("FAIL a_unexpected_out: got %h, required no output", a_out);
                end else begin
                    exp = qa.pop_front();
                    if (a_out !== exp) begin
                        fails++;
                        $display("FAIL a_out_byte: got %h, required %h", a_out, exp);
                    end
                end
            end
            a_hold      = a_out_valid && !a_out_ready;
            a_hold_data = a_out;

            if (b_hold) begin
                tests_run++;
                if (b_out_valid !== 1'b1 || b_out !== b_hold_data) begin
                    fails++;
                    $display("FAIL b_stall_hold: valid=%b data=%h, required valid=1 data=%h",
                             b_out_valid, b_out, b_hold_data);
                end
            end
            if (b_out_valid && b_out_ready) begin
                tests_run++;
                if (qb.size() == 0) begin
                    fails++;
                    $display("FAIL b_unexpected_out: got %h, required no output", b_out);
                end else begin
                    exp = qb.pop_front();
                    if (b_out !== exp) begin
                        fails++;
                        $display("FAIL b_out_byte: got %h, required %h", b_out, exp);
                    end
                end
            end
            b_hold      = b_out_valid && !b_out_ready;
            b_hold_data = b_out;

            if (chk_b_level) begin
                tests_run++;
                if (b_level > 3'(DEPTH_B)) begin
                    fails++;
                    $display("FAIL b_level_bound: got %0d, required <= %0d", b_level, DEPTH_B);
                end
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic drain_a(input int max_cycles);
        int n = 0;
        while ((qa.size() != 0 || a_out_valid) && n < max_cycles) begin
            tick();
            n++;
        end
        tests_run++;
        if (qa.size() != 0 || a_out_valid !== 1'b0) begin
            fails++;
            $display("FAIL a_drain: %0d bytes outstanding valid=%b, required 0 outstanding valid=0",
                     qa.size(), a_out_valid);
        end
    endtask

    task automatic drain_b(input int max_cycles);
        int n = 0;
        while ((qb.size() != 0 || b_out_valid) && n < max_cycles) begin
            tick();
            n++;
        end
        tests_run++;
        if (qb.size() != 0 || b_out_valid !== 1'b0) begin
            fails++;
            $display("FAIL b_drain: %0d bytes outstanding valid=%b, required 0 outstanding valid=0",
                     qb.size(), b_out_valid);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tests_run++;
        if (a_out_valid !== 1'b0 || a_out !== 8'h00) begin
            fails++;
            $display("FAIL reset_out: valid=%b data=%h, required valid=0 data=00", a_out_valid, a_out);
        end
        tests_run++;
        if (a_level !== 10'd0 || a_ovf !== 1'b0 || a_in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_status: level=%0d ovf=%b ready=%b, required 0 0 1",
                     a_level, a_ovf, a_in_ready);
        end
        tests_run++;
        if (b_out_valid !== 1'b0 || b_level !== 3'd0 || b_in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_b: valid=%b level=%0d ready=%b, required 0 0 1",
                     b_out_valid, b_level, b_in_ready);
        end
    endtask

    task automatic test_basic_latency();
        a_out_ready = 1'b1;
        a_in_raw    = 1'b0;
        a_in_valid  = 1'b1;
        a_in        = 8'h01;
        push_exp_a(8'h01, 1'b0);
        tick();
        a_in = 8'hff;
        push_exp_a(8'hff, 1'b0);
        tick();
        tests_run++;
        if (a_out_valid !== 1'b0) begin
            fails++;
            $display("FAIL latency_t1: valid=%b, required 0", a_out_valid);
        end
        a_in = 8'h02;
        push_exp_a(8'h02, 1'b0);
        tick();
        a_in_valid = 1'b0;
        tests_run++;
        if (a_out_valid !== 1'b1 || a_out !== 8'h01) begin
            fails++;
            $display("FAIL latency_t2: valid=%b data=%h, required valid=1 data=01", a_out_valid, a_out);
        end
        drain_a(50);
        tests_run++;
        if (a_level !== 10'd0) begin
            fails++;
            $display("FAIL basic_level: got %0d, required 0", a_level);
        end
    endtask

    task automatic test_raw_marker();
        logic [7:0] d [4];
        logic       r [4];
        d[0] = 8'hff; r[0] = 1'b0;
        d[1] = 8'hff; r[1] = 1'b0;
        d[2] = 8'hff; r[2] = 1'b1;
        d[3] = 8'hd9; r[3] = 1'b1;
        a_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_in_valid = 1'b1;
            a_in       = d[i];
            a_in_raw   = r[i];
            push_exp_a(d[i], r[i]);
            tick();
        end
        a_in_valid = 1'b0;
        a_in_raw   = 1'b0;
        drain_a(50);
    endtask

    task automatic test_full_overflow();
        int n = 0;
        a_out_ready = 1'b0;
        a_in_raw    = 1'b0;
        // The output register absorbs the first byte, so DEPTH+1 writes fill the FIFO
        while (a_in_ready && n < int'(DEPTH_A) + 8) begin
            a_in_valid = 1'b1;
            a_in       = 8'(n);
            push_exp_a(8'(n), 1'b0);
            tick();
            n++;
        end
        a_in_valid = 1'b0;
        tests_run++;
        if (n != int'(DEPTH_A) + 1 || a_level !== 10'(DEPTH_A) || a_in_ready !== 1'b0) begin
            fails++;
            $display("FAIL full_state: writes=%0d level=%0d ready=%b, required %0d %0d 0",
                     n, a_level, a_in_ready, DEPTH_A + 1, DEPTH_A);
        end
        a_in_valid = 1'b1;
        a_in       = 8'ha5;
        tick();
        a_in_valid = 1'b0;
        tests_run++;
        if (a_ovf !== 1'b1 || a_level !== 10'(DEPTH_A)) begin
            fails++;
            $display("FAIL overflow_set: ovf=%b level=%0d, required 1 %0d", a_ovf, a_level, DEPTH_A);
        end
        a_out_ready = 1'b1;
        drain_a(2000);
        tests_run++;
        if (a_level !== 10'd0 || a_ovf !== 1'b1) begin
            fails++;
            $display("FAIL overflow_sticky: level=%0d ovf=%b, required 0 1", a_level, a_ovf);
        end
    endtask

    task automatic test_stall_random();
        int sent = 0;
        int cyc  = 0;
        a_in_raw = 1'b0;
        while ((sent < 16 || qa.size() != 0 || a_out_valid) && cyc < 400) begin
            a_out_ready = 1'($urandom_range(0, 1));
            if (sent < 16 && a_in_ready) begin
                a_in_valid = 1'b1;
                a_in       = 8'hff;
                push_exp_a(8'hff, 1'b0);
                sent++;
            end else begin
                a_in_valid = 1'b0;
            end
            tick();
            cyc++;
        end
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        drain_a(50);
    endtask

    task automatic test_reset_mid_stuff();
        int n = 0;
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in        = 8'hff;
        a_in_raw    = 1'b0;
        push_exp_a(8'hff, 1'b0);
        tick();
        a_in_valid = 1'b0;
        while (!a_out_valid && n < 10) begin
            tick();
            n++;
        end
        tests_run++;
        if (a_out_valid !== 1'b1 || a_out !== 8'hff) begin
            fails++;
            $display("FAIL stuff_setup: valid=%b data=%h, required valid=1 data=ff", a_out_valid, a_out);
        end
        a_out_ready = 1'b1;
        tick();
        a_out_ready = 1'b0;
        tests_run++;
        if (a_out_valid !== 1'b1 || a_out !== 8'h00) begin
            fails++;
            $display("FAIL stuff_pending: valid=%b data=%h, required valid=1 data=00", a_out_valid, a_out);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        qa.delete();
        qb.delete();
        tests_run++;
        if (a_out_valid !== 1'b0 || a_out !== 8'h00 || a_level !== 10'd0 || a_ovf !== 1'b0
            || a_in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_mid_stuff: valid=%b data=%h level=%0d ovf=%b ready=%b, required 0 00 0 0 1",
                     a_out_valid, a_out, a_level, a_ovf, a_in_ready);
        end
        a_out_ready = 1'b1;
        a_in_valid  = 1'b1;
        a_in        = 8'h55;
        push_exp_a(8'h55, 1'b0);
        tick();
        a_in_valid = 1'b0;
        drain_a(20);
        for (int i = 0; i < 5; i++) tick();
        tests_run++;
        if (a_out_valid !== 1'b0 || a_level !== 10'd0) begin
            fails++;
            $display("FAIL post_reset_idle: valid=%b level=%0d, required 0 0", a_out_valid, a_level);
        end
    endtask

    task automatic test_wrap_small();
        int         sent = 0;
        int         cyc  = 0;
        logic [7:0] d;
        logic       r;
        chk_b_level = 1'b1;
        while ((sent < 20 || qb.size() != 0 || b_out_valid) && cyc < 600) begin
            b_out_ready = ($urandom_range(0, 2) != 0);
            if (sent < 20 && b_in_ready) begin
                d = ($urandom_range(0, 2) == 0) ? 8'hff : 8'($urandom);
                r = ($urandom_range(0, 3) == 0);
                b_in_valid = 1'b1;
                b_in       = d;
                b_in_raw   = r;
                push_exp_b(d, r);
                sent++;
            end else begin
                b_in_valid = 1'b0;
            end
            tick();
            cyc++;
        end
        b_in_valid  = 1'b0;
        b_out_ready = 1'b1;
        drain_b(50);
        chk_b_level = 1'b0;
        tests_run++;
        if (sent != 20 || b_level !== 3'd0 || b_ovf !== 1'b0) begin
            fails++;
            $display("FAIL wrap_end: sent=%0d level=%0d ovf=%b, required 20 0 0", sent, b_level, b_ovf);
        end
    endtask

    initial begin
        reset       = 1'b1;
        a_in_valid  = 1'b0;
        a_in        = 8'h00;
        a_in_raw    = 1'b0;
        a_out_ready = 1'b0;
        b_in_valid  = 1'b0;
        b_in        = 8'h00;
        b_in_raw    = 1'b0;
        b_out_ready = 1'b0;
        a_hold      = 1'b0;
        b_hold      = 1'b0;
        a_hold_data = 8'h00;
        b_hold_data = 8'h00;
        chk_b_level = 1'b0;

        test_reset();
        test_basic_latency();
        test_raw_marker();
        test_full_overflow();
        test_stall_random();
        test_reset_mid_stuff();
        test_wrap_small();

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
